dkong_input_cond: RTL

- Conditioning stage directly upstream of the system's control inputs (p1_*, p2_*, p1_sw, p2_sw, coin_sw).
- Takes raw, asynchronous, bouncy cabinet switches and produces clean, synchronised, active-high levels.
- Enforces joystick exclusivity and frame-aligned sampling for the game CPU.
- Shapes the coin switch into a fixed-width credit pulse with hold-off.

---
 rtl/dkong_input_pkg.sv | 23 ++
 rtl/input_debounce.sv | 49 ++++
 rtl/dkong_input_cond.sv | 92 +++++++++
 3 files changed

// File: rtl/dkong_input_pkg.sv
// dkong_input_pkg: shared types, bundle indices and joystick cleanup helper
package dkong_input_pkg;
    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF, WAIT_REL} coin_state_t;
    localparam int IDX_R   = 0;
    localparam int IDX_L   = 1;
    localparam int IDX_U   = 2;
    localparam int IDX_D   = 3;
    localparam int IDX_B1  = 4;
    localparam int NUM_RAW = 13;
    function automatic logic [4:0] joy_clean(input logic [4:0] j);
        logic [4:0] c;
        c = j;
        if (j[IDX_L] && j[IDX_R]) begin
            c[IDX_L] = 1'b0;
            c[IDX_R] = 1'b0;
        end
        if (j[IDX_U] && j[IDX_D]) begin
            c[IDX_U] = 1'b0;
            c[IDX_D] = 1'b0;
        end
        return c;
    endfunction
endpackage

// File: rtl/input_debounce.sv
// input_debounce: two-flop synchroniser plus per-bit stable-count debounce
module input_debounce #(
    parameter int WIDTH           = 13,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic             masterclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    always_ff @(posedge masterclk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
        end
    end
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable = r_s2;
        end else begin : g_db
            localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
            logic [WIDTH-1:0] r_stable;
            logic [CW-1:0]    r_cnt [WIDTH];
            always_ff @(posedge masterclk) begin
                if (rst) begin
                    r_stable <= '0;
                    for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_s2[i] == r_stable[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                            r_stable[i] <= r_s2[i];
                            r_cnt[i]    <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                end
            end
            assign stable = r_stable;
        end
    endgenerate
endmodule

// File: rtl/dkong_input_cond.sv
// dkong_input_cond: cabinet switch conditioning, frame latching and coin pulse shaping
module dkong_input_cond
    import dkong_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 65536,
    parameter int COIN_PULSE_CYCLES   = 2000000,
    parameter int COIN_HOLDOFF_CYCLES = 4000000,
    parameter int FRAME_LATCH         = 1
) (
    input  logic       masterclk,
    input  logic       rst,
    input  logic       vblk,
    input  logic [4:0] p1_raw,
    input  logic [4:0] p2_raw,
    input  logic [1:0] start_raw,
    input  logic       coin_raw,
    output logic       p1_r,
    output logic       p1_l,
    output logic       p1_u,
    output logic       p1_d,
    output logic       p1_b1,
    output logic       p2_r,
    output logic       p2_l,
    output logic       p2_u,
    output logic       p2_d,
    output logic       p2_b1,
    output logic       p1_sw,
    output logic       p2_sw,
    output logic       coin_sw,
    output logic [7:0] coin_count
);
    localparam int CMAX = (COIN_PULSE_CYCLES > COIN_HOLDOFF_CYCLES) ? COIN_PULSE_CYCLES : COIN_HOLDOFF_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    logic [NUM_RAW-1:0] w_stable;
    logic [11:0]        w_clean;
    logic               w_load;
    logic               w_coin;
    logic               w_rise;
    logic               r_vblk_d;
    logic [11:0]        r_out;
    logic               r_coin_prev;
    logic [CW-1:0]      r_cnt;
    logic [7:0]         r_count;
    coin_state_t        r_state;
    coin_state_t        w_next;
    input_debounce #(
        .WIDTH          (NUM_RAW),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .masterclk(masterclk),
        .rst      (rst),
        .raw      ({coin_raw, start_raw, p2_raw, p1_raw}),
        .stable   (w_stable)
    );
    assign w_clean = {w_stable[11:10], joy_clean(w_stable[9:5]), joy_clean(w_stable[4:0])};
    assign w_load  = (FRAME_LATCH == 0) || (vblk && !r_vblk_d);
    assign w_coin  = w_stable[12];
    assign w_rise  = w_coin && !r_coin_prev;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_rise ? PULSE : IDLE;
            PULSE:    w_next = (r_cnt == CW'(COIN_PULSE_CYCLES - 1)) ? ((COIN_HOLDOFF_CYCLES == 0) ? WAIT_REL : HOLDOFF) : PULSE;
            HOLDOFF:  w_next = (r_cnt == CW'(COIN_HOLDOFF_CYCLES - 1)) ? WAIT_REL : HOLDOFF;
            WAIT_REL: w_next = w_coin ? WAIT_REL : IDLE;
            default:  w_next = IDLE;
        endcase
    end
    always_ff @(posedge masterclk) begin
        if (rst) begin
            r_vblk_d    <= 1'b0;
            r_out       <= '0;
            r_coin_prev <= 1'b0;
            r_cnt       <= '0;
            r_count     <= '0;
            r_state     <= IDLE;
        end else begin
            r_vblk_d    <= vblk;
            r_out       <= w_load ? w_clean : r_out;
            r_coin_prev <= w_coin;
            r_state     <= w_next;
            // counter only runs while staying in a timed state; every entry starts at zero
            r_cnt       <= (w_next == r_state && (r_state == PULSE || r_state == HOLDOFF)) ? r_cnt + 1'b1 : '0;
            r_count     <= (r_state == IDLE && w_next == PULSE) ? r_count + 8'd1 : r_count;
        end
    end
    assign {p1_b1, p1_d, p1_u, p1_l, p1_r} = r_out[4:0];
    assign {p2_b1, p2_d, p2_u, p2_l, p2_r} = r_out[9:5];
    assign {p2_sw, p1_sw}                  = r_out[11:10];
    assign coin_sw                         = (r_state == PULSE);
    assign coin_count                      = r_count;
endmodule
